hacd_chunk_compressor: RTL

- Parametrised successor to the HACD single-chunk zero compressor.
- Scans a page of NUM_CHUNKS x LINES_PER_CHUNK cache lines from the read FIFO and classifies each chunk as all-zero or not.
- If enough chunks are zero, emits one header line followed by every non-zero chunk, in ascending index order, into the write FIFO.
- Reports compressed size, incompressible status and bus errors to the HACD control FSM.

---
 rtl/hacd_chunk_compressor.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hacd_chunk_compressor.sv
// HACD page compressor: scans NUM_CHUNKS chunks, drops all-zero chunks,
// and streams a header plus the surviving chunks to the write FIFO.
module hacd_chunk_compressor #(
  parameter int DATA_WIDTH      = 512,
  parameter int NUM_CHUNKS      = 4,
  parameter int LINES_PER_CHUNK = 16,
  parameter int MIN_ZERO_CHUNKS = 3,
  parameter int FIFO_PTR_WIDTH  = 6,
  parameter int SIZE_W          = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      comp_start,
  input  logic                      rdfifo_empty,
  output logic                      rd_req,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic [1:0]                rd_rresp,
  input  logic                      rd_valid,
  output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
  output logic                      ld_rdfifo_rdptr,
  input  logic                      wrfifo_full,
  output logic                      wr_req,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [NUM_CHUNKS-1:0]     zero_chunk_vec,
  output logic [SIZE_W-1:0]         comp_size,
  output logic                      incompressible,
  output logic                      comp_done,
  output logic                      bus_error
);

  localparam int TOTAL = NUM_CHUNKS * LINES_PER_CHUNK;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int LPC_W = $clog2(LINES_PER_CHUNK);
  localparam int CH_W  = $clog2(NUM_CHUNKS);
  localparam int ZC_W  = $clog2(LINES_PER_CHUNK + 1);
  localparam int NZ_W  = $clog2(NUM_CHUNKS + 1);

  localparam logic [CNT_W-1:0]  PAGE_LINES  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  CHUNK_LINES = CNT_W'(LINES_PER_CHUNK);
  localparam logic [CNT_W-1:0]  LAST_LINE   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  LAST_IN_CH  = CNT_W'(LINES_PER_CHUNK - 1);
  localparam logic [ZC_W-1:0]   FULL_ZERO   = ZC_W'(LINES_PER_CHUNK);
  localparam logic [SIZE_W-1:0] FULL_SIZE   = SIZE_W'(TOTAL * BYTES);
  localparam logic [NZ_W-1:0]   MIN_ZC      = NZ_W'(MIN_ZERO_CHUNKS);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DECIDE, S_HDR,
    S_LOAD_PTR, S_XFER, S_DONE, S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          issued_q, issued_d;
  logic [CNT_W-1:0]          line_q, line_d;
  logic [ZC_W-1:0]           czero_q, czero_d;
  logic [NUM_CHUNKS-1:0]     zvec_q, zvec_d;
  logic [NUM_CHUNKS-1:0]     sent_q, sent_d;
  logic [CH_W-1:0]           cur_q, cur_d;
  logic [NZ_W-1:0]           nz_q, nz_d;
  logic                      rd_req_q, rd_req_d;
  logic                      ld_q, ld_d;
  logic [FIFO_PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                      wr_req_q, wr_req_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [SIZE_W-1:0]         size_q, size_d;
  logic                      inc_q, inc_d;
  logic                      done_q, done_d;
  logic                      berr_q, berr_d;

  logic                      ok_valid, bad_valid;
  logic [NZ_W-1:0]           zc;
  logic [NUM_CHUNKS-1:0]     pend, pend_rest;
  logic [CH_W-1:0]           sel;
  logic [CH_W-1:0]           chunk;
  logic [ZC_W-1:0]           czero_inc;
  logic [SIZE_W-1:0]         size_c;

  always_comb begin
    ok_valid  = rd_valid && (rd_rresp == 2'b00);
    bad_valid = rd_valid && (rd_rresp != 2'b00);
    zc = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      zc = zc + NZ_W'(zvec_q[i]);
    end
    pend      = ~zvec_q & ~sent_q;
    pend_rest = pend & ~(NUM_CHUNKS'(1) << cur_q);
    // Downward scan leaves the lowest pending index in sel
    sel = '0;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if (pend[i]) sel = CH_W'(i);
    end
    chunk     = CH_W'(line_q >> LPC_W);
    czero_inc = czero_q + ZC_W'(rd_data == '0);
    size_c    = SIZE_W'((1 + int'(nz_q) * LINES_PER_CHUNK) * BYTES);
  end

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    line_d    = line_q;
    czero_d   = czero_q;
    zvec_d    = zvec_q;
    sent_d    = sent_q;
    cur_d     = cur_q;
    nz_d      = nz_q;
    rd_req_d  = 1'b0;
    ld_d      = 1'b0;
    ptr_d     = ptr_q;
    wr_req_d  = 1'b0;
    wr_data_d = wr_data_q;
    size_d    = size_q;
    inc_d     = inc_q;
    done_d    = done_q;
    berr_d    = berr_q;
    unique case (state_q)
      S_IDLE: begin
        if (comp_start && !rdfifo_empty) begin
          state_d  = S_SCAN;
          issued_d = '0;
          line_d   = '0;
          czero_d  = '0;
          zvec_d   = '0;
          sent_d   = '0;
          cur_d    = '0;
          nz_d     = '0;
        end
      end
      S_SCAN: begin
        if (!rdfifo_empty && issued_q < PAGE_LINES) begin
          rd_req_d = 1'b1;
          issued_d = issued_q + 1'b1;
        end
        if (ok_valid) begin
          line_d = line_q + 1'b1;
          if ((line_q & LAST_IN_CH) == LAST_IN_CH) begin
            zvec_d[chunk] = (czero_inc == FULL_ZERO);
            czero_d = '0;
          end else begin
            czero_d = czero_inc;
          end
          if (line_q == LAST_LINE) state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (zc >= MIN_ZC) begin
          nz_d    = NZ_W'(NUM_CHUNKS) - zc;
          state_d = S_HDR;
        end else begin
          inc_d   = 1'b1;
          size_d  = FULL_SIZE;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_HDR: begin
        if (!wrfifo_full) begin
          wr_req_d  = 1'b1;
          wr_data_d = '0;
          wr_data_d[NUM_CHUNKS+4:0] = {5'(nz_q), zvec_q};
          size_d = size_c;
          if (nz_q != '0) begin
            state_d = S_LOAD_PTR;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD_PTR: begin
        ptr_d    = FIFO_PTR_WIDTH'(int'(sel) * LINES_PER_CHUNK);
        ld_d     = 1'b1;
        cur_d    = sel;
        issued_d = '0;
        line_d   = '0;
        state_d  = S_XFER;
      end
      S_XFER: begin
        if (!rdfifo_empty && !wrfifo_full
            && issued_q < CHUNK_LINES) begin
          rd_req_d = 1'b1;
          issued_d = issued_q + 1'b1;
        end
        // In-flight responses are written even while the FIFO is full
        if (ok_valid) begin
          wr_req_d      = 1'b1;
          wr_data_d     = rd_data;
          sent_d[cur_q] = 1'b1;
          line_d        = line_q + 1'b1;
          if (line_q == LAST_IN_CH) begin
            if (pend_rest != '0) begin
              state_d = S_LOAD_PTR;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (comp_start) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          inc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        berr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (bad_valid) begin
      state_d  = S_ERR;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
      ld_d     = 1'b0;
      done_d   = 1'b0;
      berr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      issued_q  <= '0;
      line_q    <= '0;
      czero_q   <= '0;
      zvec_q    <= '0;
      sent_q    <= '0;
      cur_q     <= '0;
      nz_q      <= '0;
      rd_req_q  <= 1'b0;
      ld_q      <= 1'b0;
      ptr_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      size_q    <= '0;
      inc_q     <= 1'b0;
      done_q    <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      line_q    <= line_d;
      czero_q   <= czero_d;
      zvec_q    <= zvec_d;
      sent_q    <= sent_d;
      cur_q     <= cur_d;
      nz_q      <= nz_d;
      rd_req_q  <= rd_req_d;
      ld_q      <= ld_d;
      ptr_q     <= ptr_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      size_q    <= size_d;
      inc_q     <= inc_d;
      done_q    <= done_d;
      berr_q    <= berr_d;
    end
  end

  assign rd_req          = rd_req_q;
  assign ld_rdfifo_rdptr = ld_q;
  assign rdfifo_rdptr    = ptr_q;
  assign wr_req          = wr_req_q;
  assign wr_data         = wr_data_q;
  assign zero_chunk_vec  = zvec_q;
  assign comp_size       = size_q;
  assign incompressible  = inc_q;
  assign comp_done       = done_q;
  assign bus_error       = berr_q;

endmodule
